// File: rtl/sat_offset_subtractor_if.sv
// Stream, config and status signals of the saturating offset subtractor.
// The DUT connects through the slave modport; the driver side uses master.
interface sat_offset_subtractor_if #(
    parameter int N        = 16,
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16
);
    localparam int CH_W = $clog2(CHANNELS);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_addr;
    logic [N-1:0]     cfg_data;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_last;
    logic             out_sat;

    logic [CNT_W-1:0] sat_count;

    modport master (
        output cfg_we, cfg_addr, cfg_data,
        output in_valid, in_data, in_last,
        output out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat, sat_count
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data,
        input  in_valid, in_data, in_last,
        input  out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat, sat_count
    );
endinterface

// File: rtl/sat_offset_subtractor.sv
// Saturating out = in - offset[ch], per-channel offsets, channel advances per accepted sample.
// Two registered stages, 2-cycle latency, full throughput; stalls propagate back through in_ready.
module sat_offset_subtractor #(
    parameter int N        = 16,
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    sat_offset_subtractor_if.slave bus
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]     offset [CHANNELS];
    logic [CH_W-1:0]  ch;

    logic             s1_valid;
    logic             s1_last;
    logic [N-1:0]     s1_a;
    logic [N-1:0]     s1_b;

    logic             s2_valid;
    logic             s2_last;
    logic             s2_sat;
    logic [N-1:0]     s2_data;

    logic [CNT_W-1:0] sat_cnt;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             deliver;
    logic             cfg_hit;
    logic [N-1:0]     raw;
    logic [N-1:0]     diff;
    logic             ovf;

    assign s2_adv  = !s2_valid || bus.out_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign accept  = bus.in_valid && s1_adv;
    assign deliver = s2_valid && bus.out_ready;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_last  = s2_last;
    assign bus.out_sat   = s2_sat;
    assign bus.sat_count = sat_cnt;

    // Out-of-range addresses only exist when CHANNELS is not a power of two.
    generate
        if ((2 ** CH_W) > CHANNELS) begin : g_addr_chk
            assign cfg_hit = bus.cfg_we &&
                             ({{(32-CH_W){1'b0}}, bus.cfg_addr} < 32'(CHANNELS));
        end else begin : g_addr_full
            assign cfg_hit = bus.cfg_we;
        end
    endgenerate

    always_comb begin
        raw  = s1_a - s1_b;
        ovf  = (s1_a[N-1] ^ s1_b[N-1]) & (raw[N-1] ^ s1_a[N-1]);
        diff = raw;
        if (ovf) begin
            diff = s1_a[N-1] ? MIN_VAL : MAX_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                offset[i] <= '0;
            end
        end else if (cfg_hit) begin
            offset[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
        end else if (accept) begin
            if (bus.in_last || (ch == CH_W'(CHANNELS - 1))) begin
                ch <= '0;
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

    // Offset is captured at accept, so a same-edge config write only affects later samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a    <= bus.in_data;
                s1_b    <= offset[ch];
                s1_last <= bus.in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= diff;
                s2_sat  <= ovf;
                s2_last <= s1_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (deliver && s2_sat && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sat_offset_subtractor.sv
// Bench for sat_offset_subtractor: directed spec scenarios plus a randomized run
// against a plain-arithmetic reference model with an expected-result queue.
module tb_sat_offset_subtractor;
    localparam int N        = 16;
    localparam int CHANNELS = 8;
    localparam int CNT_W    = 16;
    localparam int CH_W     = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sat_offset_subtractor_if #(.N(N), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

    sat_offset_subtractor #(.N(N), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] model_off [CHANNELS];
    int          model_ch;
    int          sat_exp;

    logic [15:0] exp_d [$];
    logic        exp_s [$];
    logic        exp_l [$];
    logic [15:0] got_d [$];
    logic        got_s [$];
    logic        got_l [$];
    logic [15:0] stim_d [$];
    logic        stim_l [$];
    int          acc_cnt;
    int          drv_cycles;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer difference, clamped to the signed 16-bit range.
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic s);
        int r;
        r = int'($signed(a)) - int'($signed(b));
        if (r > 32767) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (r < -32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = r[15:0]; s = 1'b0;
        end
    endfunction

    function automatic void model_accept(input logic [15:0] a, input logic l);
        logic [15:0] d;
        logic        s;
        ref_sub(a, model_off[model_ch], d, s);
        exp_d.push_back(d);
        exp_s.push_back(s);
        exp_l.push_back(l);
        model_ch = (l || model_ch == CHANNELS - 1) ? 0 : model_ch + 1;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       rnd16 = 16'h7FFF - 16'($urandom_range(0, 3));
            1:       rnd16 = 16'h8000 + 16'($urandom_range(0, 3));
            default: rnd16 = 16'($urandom);
        endcase
    endfunction

    task automatic clear_queues();
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        got_d.delete(); got_s.delete(); got_l.delete();
        stim_d.delete(); stim_l.delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) model_off[i] = 16'h0000;
        model_ch = 0;
        sat_exp  = 0;
        clear_queues();
    endtask

    task automatic do_reset();
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] a, input logic [15:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        model_off[a] = d;
    endtask

    // Single sample with in_last (channel returns to 0); returns result and accept->valid latency.
    task automatic run_one(input logic [15:0] d, output logic [15:0] od, output logic os,
                           output logic ol, output int lat);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_ch = 0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        od = bus.out_data;
        os = bus.out_sat;
        ol = bus.out_last;
        @(posedge clk); #1;
    endtask

    task automatic drive_stream();
        int   i = 0;
        int   guard = 0;
        logic acc;
        acc_cnt = 0;
        while (i < stim_d.size() && guard < 500) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_d[i];
            bus.in_last  = stim_l[i];
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                acc_cnt++;
            end
            guard++;
        end
        drv_cycles   = guard;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (i < stim_d.size()) begin
            checks++; errors++;
            $display("FAIL drive_timeout: accepted %0d required %0d", i, stim_d.size());
        end
    endtask

    task automatic collect(input int n);
        int guard = 0;
        while (got_d.size() < n && guard < 500) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_d.push_back(bus.out_data);
                got_s.push_back(bus.out_sat);
                got_l.push_back(bus.out_last);
            end
            guard++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); end
        checks++; if (bus.sat_count !== 16'h0000) begin errors++; $display("FAIL reset_sat_count: got %0d want 0", bus.sat_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] od; logic os, ol; int lat;
        cfg_write(3'd0, 16'd3);
        run_one(16'd5, od, os, ol, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
        checks++; if (od !== 16'd2) begin errors++; $display("FAIL basic_data: got %h want 0002", od); end
        checks++; if (os !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", os); end
        checks++; if (ol !== 1'b1) begin errors++; $display("FAIL basic_last: got %b want 1", ol); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_dup: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_pos_sat();
        logic [15:0] od; logic os, ol; int lat;
        cfg_write(3'd0, 16'hFFFF);
        run_one(16'h7FFF, od, os, ol, lat);
        sat_exp++;
        checks++; if (od !== 16'h7FFF) begin errors++; $display("FAIL possat_data: got %h want 7fff", od); end
        checks++; if (os !== 1'b1) begin errors++; $display("FAIL possat_sat: got %b want 1", os); end
        checks++; if (bus.sat_count !== 16'(sat_exp)) begin errors++; $display("FAIL possat_count: got %0d want %0d", bus.sat_count, sat_exp); end
    endtask

    task automatic test_neg_sat();
        logic [15:0] od; logic os, ol; int lat;
        cfg_write(3'd0, 16'h0001);
        run_one(16'h8000, od, os, ol, lat);
        sat_exp++;
        checks++; if (od !== 16'h8000) begin errors++; $display("FAIL negsat_data: got %h want 8000", od); end
        checks++; if (os !== 1'b1) begin errors++; $display("FAIL negsat_sat: got %b want 1", os); end
        cfg_write(3'd0, 16'h8000);
        run_one(16'h8000, od, os, ol, lat);
        checks++; if (od !== 16'h0000) begin errors++; $display("FAIL minmin_data: got %h want 0000", od); end
        checks++; if (os !== 1'b0) begin errors++; $display("FAIL minmin_sat: got %b want 0", os); end
        checks++; if (bus.sat_count !== 16'(sat_exp)) begin errors++; $display("FAIL negsat_count: got %0d want %0d", bus.sat_count, sat_exp); end
    endtask

    task automatic test_channel_walk();
        for (int k = 0; k < CHANNELS; k++) cfg_write(CH_W'(k), 16'(k * 10));
        for (int pass = 0; pass < 2; pass++) begin
            clear_queues();
            // Pass 0: ten plain samples wrap the channel; pass 1: in_last on the 3rd resets it.
            for (int i = 0; i < ((pass == 0) ? 10 : 5); i++) begin
                stim_d.push_back(16'd100);
                stim_l.push_back(pass == 1 && i == 2);
                model_accept(16'd100, pass == 1 && i == 2);
            end
            bus.out_ready = 1'b1;
            fork
                drive_stream();
                collect(stim_d.size());
            join
            checks++; if (drv_cycles !== stim_d.size()) begin errors++; $display("FAIL walk_throughput: %0d cycles want %0d", drv_cycles, stim_d.size()); end
            checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL walk_count: got %0d want %0d", got_d.size(), exp_d.size()); end
            for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i] || got_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL walk_item%0d_%0d: got %0d/%b/%b want %0d/%b/%b", pass, i,
                             got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]);
                end
                sat_exp += int'(exp_s[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        logic        seen;
        logic        unstable;
        clear_queues();
        for (int i = 0; i < 6; i++) begin
            stim_d.push_back(rnd16());
            stim_l.push_back(i == 5);
            model_accept(stim_d[i], stim_l[i]);
        end
        bus.out_ready = 1'b0;
        seen = 1'b0; unstable = 1'b0; held = '0;
        fork
            drive_stream();
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (bus.out_valid === 1'b1) begin
                        if (seen && bus.out_data !== held) unstable = 1'b1;
                        held = bus.out_data;
                        seen = 1'b1;
                    end
                end
                checks++; if (acc_cnt !== 2) begin errors++; $display("FAIL bp_buffered: accepted %0d want 2", acc_cnt); end
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
                checks++; if (!seen || unstable) begin errors++; $display("FAIL bp_stable: seen %b unstable %b want 1 0", seen, unstable); end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                collect(6);
            end
        join
        checks++; if (got_d.size() !== 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i] || got_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL bp_item%0d: got %h/%b/%b want %h/%b/%b", i,
                         got_d[i], got_s[i], got_l[i], exp_d[i], exp_s[i], exp_l[i]);
            end
            sat_exp += int'(exp_s[i]);
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] od; logic os, ol; int lat;
        logic        spurious;
        checks++; if (bus.sat_count !== 16'(sat_exp)) begin errors++; $display("FAIL pre_rst_count: got %0d want %0d", bus.sat_count, sat_exp); end
        cfg_write(3'd0, 16'h0100);
        clear_queues();
        stim_d.push_back(16'h1111); stim_l.push_back(1'b0);
        stim_d.push_back(16'h2222); stim_l.push_back(1'b0);
        bus.out_ready = 1'b0;
        drive_stream();
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_full: out_valid %b in_ready %b want 1 0", bus.out_valid, bus.in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.sat_count !== 16'h0000) begin errors++; $display("FAIL rst_async_count: got %0d want 0", bus.sat_count); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.out_ready = 1'b1;
        spurious = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) spurious = 1'b1;
        end
        checks++; if (spurious) begin errors++; $display("FAIL rst_flush: out_valid seen 1 want 0"); end
        run_one(16'h1234, od, os, ol, lat);
        checks++; if (od !== 16'h1234 || os !== 1'b0) begin errors++; $display("FAIL rst_offset_zero: got %h/%b want 1234/0", od, os); end
    endtask

    task automatic test_random();
        logic [15:0] d; logic s, l;
        int          spurious = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c < 1000) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_data   = rnd16();
                bus.in_last   = ($urandom_range(0, 7) == 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.cfg_we    = ($urandom_range(0, 7) == 0);
                bus.cfg_addr  = CH_W'($urandom_range(0, CHANNELS - 1));
                bus.cfg_data  = rnd16();
            end else begin
                bus.in_valid  = 1'b0;
                bus.cfg_we    = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_d.size() == 0) begin
                    spurious++;
                end else begin
                    d = exp_d.pop_front(); s = exp_s.pop_front(); l = exp_l.pop_front();
                    sat_exp += int'(s);
                    checks++;
                    if (bus.out_data !== d || bus.out_sat !== s || bus.out_last !== l) begin
                        errors++;
                        $display("FAIL rand_cycle%0d: got %h/%b/%b want %h/%b/%b", c,
                                 bus.out_data, bus.out_sat, bus.out_last, d, s, l);
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) model_accept(bus.in_data, bus.in_last);
            if (bus.cfg_we === 1'b1) model_off[bus.cfg_addr] = bus.cfg_data;
            @(posedge clk); #1;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rand_spurious: %0d extra results want 0", spurious); end
        checks++; if (exp_d.size() != 0) begin errors++; $display("FAIL rand_lost: %0d results missing want 0", exp_d.size()); end
        checks++; if (bus.sat_count !== 16'(sat_exp)) begin errors++; $display("FAIL rand_sat_count: got %0d want %0d", bus.sat_count, sat_exp); end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat();
        test_channel_walk();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
